spi_arbiter: RTL and testbench



---
 rtl/spi_arbiter_if.sv | 30 +++
 rtl/spi_arbiter.sv | 130 +++++++++++++
 tb/tb_spi_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arbiter_if.sv
// Requester-side and spi_master-side signals of spi_arbiter bundled in one interface.
// master: the arbiter's view; slave: the requesters plus attached spi_master.
interface spi_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int NBYTES = 1
);
    logic [NREQ-1:0]          req;
    logic [2*NREQ-1:0]        cfg;
    logic [NREQ*8*NBYTES-1:0] wdata;
    logic [NREQ-1:0]          grant;
    logic [NREQ-1:0]          done;
    logic [8*NBYTES-1:0]      rdata;
    logic [NREQ-1:0]          cs_n;
    logic                     m_cpol;
    logic                     m_cpha;
    logic [8*NBYTES-1:0]      m_din;
    logic                     m_start;
    logic [8*NBYTES-1:0]      m_dout;
    logic                     m_busy;

    modport master (
        input  req, cfg, wdata, m_dout, m_busy,
        output grant, done, rdata, cs_n, m_cpol, m_cpha, m_din, m_start
    );

    modport slave (
        output req, cfg, wdata, m_dout, m_busy,
        input  grant, done, rdata, cs_n, m_cpol, m_cpha, m_din, m_start
    );
endinterface

// File: rtl/spi_arbiter.sv
// Shares one spi_master between NREQ requesters with chip-select setup/hold/gap timing.
// Define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module spi_arbiter #(
    parameter int NBYTES   = 1,
    parameter int NREQ     = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic           clk2,
    input  logic           rst_n,
    spi_arbiter_if.master  bus
);
    localparam int W    = 8 * NBYTES;
    localparam int IW   = $clog2(NREQ);
    localparam int CMX1 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CMAX = (CMX1 > CS_GAP) ? CMX1 : CS_GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, SEL, SETUP, START, WAIT_BUSY, XFER, HOLD, GAP
    } state_t;

    state_t         state;
    logic [IW-1:0]  win;
    logic [IW-1:0]  pick;
    logic [CW-1:0]  cnt;

`ifdef SPI_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req[k]) pick = IW'(k);
    end
`else
    logic [IW-1:0]  ptr;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end
`endif

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win         <= '0;
            cnt         <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            ptr         <= '0;
`endif
            bus.cs_n    <= '1;
            bus.grant   <= '0;
            bus.done    <= '0;
            bus.rdata   <= '0;
            bus.m_start <= 1'b0;
            bus.m_din   <= '0;
            bus.m_cpol  <= 1'b0;
            bus.m_cpha  <= 1'b0;
        end else begin
            bus.done    <= '0;
            bus.m_start <= 1'b0;
            case (state)
                // A busy master here is finishing a transfer started before our reset.
                IDLE: if (|bus.req && !bus.m_busy) begin
                    win             <= pick;
`ifndef SPI_ARB_FIXED_PRIO_EN
                    ptr             <= pick;
`endif
                    bus.grant       <= '0;
                    bus.grant[pick] <= 1'b1;
                    bus.m_cpol      <= bus.cfg[2*int'(pick)+1];
                    bus.m_cpha      <= bus.cfg[2*int'(pick)];
                    bus.m_din       <= bus.wdata[int'(pick)*W +: W];
                    state           <= SEL;
                end
                // cs_n stays high for this cycle so mclk settles at the new idle level.
                SEL: begin
                    bus.cs_n[win] <= 1'b0;
                    cnt           <= '0;
                    state         <= SETUP;
                end
                SETUP: if (cnt == SETUP_LAST) begin
                    bus.m_start <= 1'b1;
                    state       <= START;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                START: state <= WAIT_BUSY;
                WAIT_BUSY: if (bus.m_busy) state <= XFER;
                XFER: if (!bus.m_busy) begin
                    cnt   <= '0;
                    state <= HOLD;
                end
                HOLD: if (cnt == HOLD_LAST) begin
                    bus.rdata     <= bus.m_dout;
                    bus.done[win] <= 1'b1;
                    bus.grant     <= '0;
                    bus.cs_n      <= '1;
                    cnt           <= '0;
                    state         <= GAP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                GAP: if (cnt == GAP_LAST) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a loopback spi_master model and a done/rdata scoreboard.
module tb_spi_arbiter;
    localparam int NREQ = 4, NBYTES = 1, CS_SETUP = 2, CS_HOLD = 2, CS_GAP = 4;
    localparam int XBITS = 16 * NBYTES;
    localparam int LAT = 1 + CS_SETUP + 1 + 1 + XBITS + CS_HOLD + 1;

    logic clk2 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk2 = ~clk2;

    spi_arbiter_if #(.NREQ(NREQ), .NBYTES(NBYTES)) bus ();

    spi_arbiter #(.NBYTES(NBYTES), .NREQ(NREQ), .CS_SETUP(CS_SETUP),
                  .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP))
        dut (.clk2(clk2), .rst_n(rst_n), .bus(bus));

    // spi_master stand-in: no reset, miso tied to mosi so dout returns din.
    logic       busy_m = 1'b0;
    logic [7:0] dout_m = 8'h00;
    int         bcnt   = 0;
    assign bus.m_busy = busy_m;
    assign bus.m_dout = dout_m;

    always @(posedge clk2) begin
        if (bus.m_start && !busy_m) begin
            busy_m <= 1'b1;
            bcnt   <= XBITS - 1;
        end else if (busy_m) begin
            if (bcnt == 0) begin
                busy_m <= 1'b0;
                dout_m <= bus.m_din;
            end else begin
                bcnt <= bcnt - 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic push(input int idx, input logic [7:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard, one-cold chip selects and post-done gap length.
    int gap_n = 0;
    bit gap_trk = 1'b0;
    always @(negedge clk2) begin
        exp_t e;
        if ($countones(~bus.cs_n) > 1)
            chk("cs_onecold", 64'(bus.cs_n), 64'hF);
        if (gap_trk) begin
            if (bus.cs_n == 4'hF) gap_n++;
            else begin
                chk("gap_ge_min", 64'(gap_n >= CS_GAP), 64'd1);
                gap_trk = 1'b0;
            end
        end
        if (rst_n && bus.done != '0) begin
            gap_trk = 1'b1;
            gap_n   = 1;
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 64'(bus.done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_who", 64'(bus.done), 64'(4'b1 << e.idx));
                chk("rdata", 64'(bus.rdata), 64'(e.data));
            end
        end
    end

    task automatic wait_grant(input int i);
        int n = 0;
        while (!bus.grant[i] && n < 300) begin @(negedge clk2); n++; end
        chk("grant_seen", 64'(bus.grant[i]), 64'd1);
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (!bus.done[i] && n < 300) begin @(negedge clk2); n++; end
        chk("done_seen", 64'(bus.done[i]), 64'd1);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!bus.m_busy && n < 100) begin @(negedge clk2); n++; end
        chk("busy_seen", 64'(bus.m_busy), 64'd1);
    endtask

    initial begin
        int  n, nd, t_cs, t_st, t_bf, t_up;
        bit  prev_busy, bad;

        bus.req   = '0;
        bus.cfg   = '0;
        bus.wdata = '0;

        // Reset state
        repeat (2) @(negedge clk2);
        chk("rst_cs_n", 64'(bus.cs_n), 64'hF);
        chk("rst_grant", 64'(bus.grant), 64'h0);
        chk("rst_done", 64'(bus.done), 64'h0);
        chk("rst_rdata", 64'(bus.rdata), 64'h0);
        chk("rst_start", 64'(bus.m_start), 64'h0);
        chk("rst_din", 64'(bus.m_din), 64'h0);
        chk("rst_cpol_cpha", 64'({bus.m_cpol, bus.m_cpha}), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk2);

        // Single requester 0, timing of cs_n around start/busy
        bus.wdata[7:0] = 8'hA5;
        bus.req = 4'b0001;
        push(0, 8'hA5);
        wait_grant(0);
        chk("sel_din", 64'(bus.m_din), 64'hA5);
        chk("sel_cs_high", 64'(bus.cs_n), 64'hF);
        n = 0; t_cs = -1; t_st = -1; t_bf = -1; t_up = -1; prev_busy = 1'b0;
        while (!bus.done[0] && n < 200) begin
            if (t_cs < 0 && !bus.cs_n[0]) t_cs = n;
            if (t_st < 0 && bus.m_start) t_st = n;
            if (t_bf < 0 && prev_busy && !bus.m_busy) t_bf = n;
            if (t_bf >= 0 && t_up < 0 && bus.cs_n[0]) t_up = n;
            prev_busy = bus.m_busy;
            @(negedge clk2);
            n++;
        end
        if (t_up < 0 && bus.cs_n[0]) t_up = n;
        bus.req = '0;
        chk("setup_len", 64'(t_st - t_cs), 64'(CS_SETUP));
        chk("hold_len", 64'(t_up - t_bf), 64'(CS_HOLD + 1));
        chk("latency", 64'(n + 1), 64'(LAT));

        // cpol=1 for requester 2; late wdata change must be ignored
        bus.cfg = 8'b0010_0000;
        bus.wdata[23:16] = 8'h3C;
        bus.req = 4'b0100;
        push(2, 8'h3C);
        wait_grant(2);
        chk("sel_cpol", 64'({bus.m_cpol, bus.m_cpha}), 64'h2);
        chk("sel_cs2_high", 64'(bus.cs_n[2]), 64'd1);
        bus.wdata[23:16] = 8'hFF;
        @(negedge clk2);
        chk("setup_cs2_low", 64'(bus.cs_n), 64'hB);
        chk("setup_cpol", 64'(bus.m_cpol), 64'd1);
        wait_done(2);
        bus.req = '0;
        bus.cfg = '0;

        // Requester 3 drops req mid-transfer
        bus.wdata[31:24] = 8'h5A;
        bus.req = 4'b1000;
        push(3, 8'h5A);
        wait_grant(3);
        wait_busy();
        repeat (4) @(negedge clk2);
        bus.req = '0;
        wait_done(3);
        repeat (40) @(negedge clk2);
        chk("idle_after_drop", 64'(bus.grant), 64'h0);

        // All four requesting
        bus.wdata = 32'h44_33_22_11;
`ifdef SPI_ARB_FIXED_PRIO_EN
        push(0, 8'h11); push(0, 8'h11); push(0, 8'h11); push(0, 8'h11); push(0, 8'h11);
`else
        push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
`endif
        bus.req = 4'b1111;
        n = 0; nd = 0;
        while (nd < 5 && n < 400) begin
            @(negedge clk2);
            n++;
            if (|bus.done) nd++;
        end
        bus.req = '0;
        chk("rr_dones", 64'(nd), 64'd5);
        repeat (10) @(negedge clk2);

        // req=1010 held
`ifdef SPI_ARB_FIXED_PRIO_EN
        push(1, 8'h22); push(1, 8'h22); push(1, 8'h22);
`else
        push(1, 8'h22); push(3, 8'h44); push(1, 8'h22);
`endif
        bus.req = 4'b1010;
        n = 0; nd = 0;
        while (nd < 3 && n < 300) begin
            @(negedge clk2);
            n++;
            if (|bus.done) nd++;
        end
        bus.req = '0;
        chk("pair_dones", 64'(nd), 64'd3);
        repeat (10) @(negedge clk2);

        // Reset pulsed during XFER while the master keeps running
        bus.wdata[15:8] = 8'h77;
        bus.req = 4'b0010;
        wait_grant(1);
        wait_busy();
        repeat (3) @(negedge clk2);
        rst_n = 1'b0;
        #1;
        chk("async_cs_n", 64'(bus.cs_n), 64'hF);
        chk("async_grant", 64'(bus.grant), 64'h0);
        chk("async_start", 64'(bus.m_start), 64'h0);
        bus.wdata[15:8] = 8'h99;
        push(1, 8'h99);
        repeat (2) @(negedge clk2);
        rst_n = 1'b1;
        n = 0; bad = 1'b0;
        while (busy_m && n < 100) begin
            if (bus.grant != '0) bad = 1'b1;
            @(negedge clk2);
            n++;
        end
        chk("no_grant_while_busy", 64'(bad), 64'd0);
        wait_grant(1);
        wait_done(1);
        bus.req = '0;

        repeat (10) @(negedge clk2);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
